// File: rtl/projectile_ball_if.sv
// Owner/opponent handshake and ball status bundle between a fighter, the
// projectile engine and the sprite renderer.
interface projectile_ball_if;
   localparam int unsigned POS_W = 10;

   logic             ending;
   logic             summon_ball;
   logic             owner_face;
   logic [POS_W-1:0] owner_x;
   logic [POS_W-1:0] owner_y;
   logic [POS_W-1:0] target_x;
   logic [POS_W-1:0] target_y;
   logic             ball_ready;
   logic             ball_active;
   logic             ball_exploding;
   logic             ball_face;
   logic [POS_W-1:0] ball_x;
   logic [POS_W-1:0] ball_y;
   logic [POS_W-1:0] damage;

   modport master (
      output ending, summon_ball, owner_face, owner_x, owner_y, target_x, target_y,
      input  ball_ready, ball_active, ball_exploding, ball_face, ball_x, ball_y, damage
   );

   modport slave (
      input  ending, summon_ball, owner_face, owner_x, owner_y, target_x, target_y,
      output ball_ready, ball_active, ball_exploding, ball_face, ball_x, ball_y, damage
   );
endinterface

// File: rtl/projectile_ball.sv
// Projectile engine: launches a ball from the owner, moves it once per frame,
// emits a one-frame damage pulse on overlap, then explodes and cools down.
module projectile_ball #(
   parameter int unsigned SPEED           = 6,
   parameter int unsigned DAMAGE          = 20,
   parameter int unsigned LAUNCH_DX       = 40,
   parameter int unsigned LAUNCH_DY       = 10,
   parameter int unsigned HIT_W           = 32,
   parameter int unsigned HIT_H           = 48,
   parameter int unsigned EXPLODE_FRAMES  = 8,
   parameter int unsigned COOLDOWN_FRAMES = 60,
   parameter int unsigned X_MIN           = 0,
   parameter int unsigned X_MAX           = 600
) (
   input  logic               frame_clk,
   input  logic               Reset,
   projectile_ball_if.slave   bus
);
   localparam int unsigned POS_W   = 10;
   localparam int unsigned EXT_W   = POS_W + 1;
   localparam int unsigned CNT_MAX = (EXPLODE_FRAMES > COOLDOWN_FRAMES) ? EXPLODE_FRAMES : COOLDOWN_FRAMES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_READY, S_FLYING, S_HIT, S_COOLDOWN} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [POS_W-1:0]   x_q, x_d, y_q, y_d, dmg_q, dmg_d;
   logic               face_q, face_d;

   logic [EXT_W-1:0]   launch_raw;
   logic               launch_under;
   logic [POS_W-1:0]   launch_x;
   logic [POS_W-1:0]   dx, dy;
   logic               overlap, at_edge;

   // Launch x: subtraction guarded by a compare so it cannot wrap below X_MIN.
   always_comb begin
      launch_under = 1'b0;
      launch_raw   = EXT_W'(bus.owner_x) + EXT_W'(LAUNCH_DX);
      if (bus.owner_face) begin
         launch_under = EXT_W'(bus.owner_x) < EXT_W'(X_MIN) + EXT_W'(LAUNCH_DX);
         launch_raw   = EXT_W'(bus.owner_x) - EXT_W'(LAUNCH_DX);
      end
      if (launch_under)                     launch_x = POS_W'(X_MIN);
      else if (launch_raw > EXT_W'(X_MAX))  launch_x = POS_W'(X_MAX);
      else                                  launch_x = launch_raw[POS_W-1:0];
   end

   assign dx      = (x_q >= bus.target_x) ? (x_q - bus.target_x) : (bus.target_x - x_q);
   assign dy      = (y_q >= bus.target_y) ? (y_q - bus.target_y) : (bus.target_y - y_q);
   assign overlap = (dx < POS_W'(HIT_W)) && (dy < POS_W'(HIT_H));
   assign at_edge = face_q ? (EXT_W'(x_q) < EXT_W'(X_MIN) + EXT_W'(SPEED))
                           : (EXT_W'(x_q) + EXT_W'(SPEED) > EXT_W'(X_MAX));

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      face_d  = face_q;
      dmg_d   = '0;
      if (!bus.ending) begin
         state_d = S_READY;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_READY: begin
               if (bus.summon_ball) begin
                  state_d = S_FLYING;
                  face_d  = bus.owner_face;
                  x_d     = launch_x;
                  y_d     = bus.owner_y + POS_W'(LAUNCH_DY);
               end
            end
            S_FLYING: begin
               if (overlap) begin
                  state_d = S_HIT;
                  cnt_d   = '0;
                  dmg_d   = POS_W'(DAMAGE);
               end else if (at_edge) begin
                  state_d = S_COOLDOWN;
                  cnt_d   = '0;
               end else begin
                  x_d = face_q ? (x_q - POS_W'(SPEED)) : (x_q + POS_W'(SPEED));
               end
            end
            S_HIT: begin
               if (cnt_q == CNT_W'(EXPLODE_FRAMES - 1)) begin
                  state_d = S_COOLDOWN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_COOLDOWN: begin
               if (cnt_q == CNT_W'(COOLDOWN_FRAMES - 1)) begin
                  state_d = S_READY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = S_READY;
         endcase
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q <= S_READY;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         face_q  <= 1'b0;
         dmg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         face_q  <= face_d;
         dmg_q   <= dmg_d;
      end
   end

   assign bus.ball_ready     = (state_q == S_READY) && bus.ending;
   assign bus.ball_active    = (state_q == S_FLYING) || (state_q == S_HIT);
   assign bus.ball_exploding = (state_q == S_HIT);
   assign bus.ball_face      = face_q;
   assign bus.ball_x         = x_q;
   assign bus.ball_y         = y_q;
   assign bus.damage         = dmg_q;
endmodule

// File: tb/tb_projectile_ball.sv
// Scoreboard bench for projectile_ball: each frame's expected outputs are queued
// with the stimulus and compared after the following rising edge.
module tb_projectile_ball;
   logic frame_clk = 1'b0;
   logic Reset;
   always #5 frame_clk = ~frame_clk;

   projectile_ball_if bus ();
   projectile_ball dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus));

   typedef struct {
      string       tag;
      int unsigned x, y, face, act, expl, rdy, dmg;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Queue the expectation for the next edge, then compare once the DUT has updated.
   task automatic frame(input string tag, input int unsigned x, input int unsigned y,
                        input int unsigned face, input int unsigned act, input int unsigned expl,
                        input int unsigned rdy, input int unsigned dmg);
      exp_t e;
      e.tag = tag; e.x = x; e.y = y; e.face = face;
      e.act = act; e.expl = expl; e.rdy = rdy; e.dmg = dmg;
      sb_q.push_back(e);
      @(posedge frame_clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check($sformatf("%s.x",    e.tag), 32'(bus.ball_x),         e.x);
         check($sformatf("%s.y",    e.tag), 32'(bus.ball_y),         e.y);
         check($sformatf("%s.face", e.tag), 32'(bus.ball_face),      e.face);
         check($sformatf("%s.act",  e.tag), 32'(bus.ball_active),    e.act);
         check($sformatf("%s.expl", e.tag), 32'(bus.ball_exploding), e.expl);
         check($sformatf("%s.rdy",  e.tag), 32'(bus.ball_ready),     e.rdy);
         check($sformatf("%s.dmg",  e.tag), 32'(bus.damage),         e.dmg);
      end
   endtask

   task automatic set_pos(input logic face, input int unsigned ox, input int unsigned oy,
                          input int unsigned tx, input int unsigned ty);
      bus.owner_face = face;
      bus.owner_x    = 10'(ox);
      bus.owner_y    = 10'(oy);
      bus.target_x   = 10'(tx);
      bus.target_y   = 10'(ty);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset           = 1'b1;
      bus.ending      = 1'b1;
      bus.summon_ball = 1'b0;
      set_pos(1'b0, 80, 300, 400, 300);

      // Reset state, then reset beating a simultaneous summon.
      frame("rst", 0, 0, 0, 0, 0, 1, 0);
      bus.summon_ball = 1'b1;
      frame("rst_sum", 0, 0, 0, 0, 0, 1, 0);
      bus.summon_ball = 1'b0;
      Reset = 1'b0;
      frame("idle", 0, 0, 0, 0, 0, 1, 0);

      // Right-facing hit with ignored summons in every busy state.
      bus.summon_ball = 1'b1;
      frame("launch", 120, 310, 0, 1, 0, 0, 0);
      bus.summon_ball = 1'b0;
      for (int k = 1; k <= 42; k++) begin
         if (k == 10) begin
            bus.summon_ball = 1'b1;
            set_pos(1'b1, 300, 200, 400, 300);
         end
         frame("fly", 120 + 6 * k, 310, 0, 1, 0, 0, 0);
         bus.summon_ball = 1'b0;
         set_pos(1'b0, 80, 300, 400, 300);
      end
      frame("hit", 372, 310, 0, 1, 1, 0, 20);
      for (int i = 1; i <= 7; i++) begin
         bus.summon_ball = (i == 2);
         frame("explode", 372, 310, 0, 1, 1, 0, 0);
      end
      for (int i = 0; i < 60; i++) begin
         bus.summon_ball = (i == 30);
         frame("cool", 372, 310, 0, 0, 0, 0, 0);
      end
      bus.summon_ball = 1'b0;
      frame("hit_rdy", 372, 310, 0, 0, 0, 1, 0);

      // Left-facing miss off the left edge.
      set_pos(1'b1, 80, 300, 400, 100);
      bus.summon_ball = 1'b1;
      frame("mlaunch", 40, 310, 1, 1, 0, 0, 0);
      bus.summon_ball = 1'b0;
      for (int k = 1; k <= 6; k++) frame("mfly", 40 - 6 * k, 310, 1, 1, 0, 0, 0);
      for (int i = 0; i < 60; i++) frame("mcool", 4, 310, 1, 0, 0, 0, 0);
      frame("miss_rdy", 4, 310, 1, 0, 0, 1, 0);

      // Launch clamp at the left limit; leave cooldown via match end.
      set_pos(1'b1, 20, 300, 400, 100);
      bus.summon_ball = 1'b1;
      frame("clampL", 0, 310, 1, 1, 0, 0, 0);
      bus.summon_ball = 1'b0;
      frame("clampL_edge", 0, 310, 1, 0, 0, 0, 0);
      bus.ending = 1'b0;
      frame("clampL_end", 0, 310, 1, 0, 0, 0, 0);
      bus.ending = 1'b1;
      frame("clampL_back", 0, 310, 1, 0, 0, 1, 0);

      // Launch clamp at the right limit.
      set_pos(1'b0, 590, 100, 400, 400);
      bus.summon_ball = 1'b1;
      frame("clampR", 600, 110, 0, 1, 0, 0, 0);
      bus.summon_ball = 1'b0;
      frame("clampR_edge", 600, 110, 0, 0, 0, 0, 0);
      bus.ending = 1'b0;
      frame("clampR_end", 600, 110, 0, 0, 0, 0, 0);
      bus.ending = 1'b1;
      frame("clampR_back", 600, 110, 0, 0, 0, 1, 0);

      // Match end mid-flight; summon held while the match is over.
      set_pos(1'b0, 80, 300, 400, 100);
      bus.summon_ball = 1'b1;
      frame("elaunch", 120, 310, 0, 1, 0, 0, 0);
      bus.summon_ball = 1'b0;
      frame("efly", 126, 310, 0, 1, 0, 0, 0);
      frame("efly", 132, 310, 0, 1, 0, 0, 0);
      bus.ending      = 1'b0;
      bus.summon_ball = 1'b1;
      frame("end", 132, 310, 0, 0, 0, 0, 0);
      frame("end_hold", 132, 310, 0, 0, 0, 0, 0);
      bus.summon_ball = 1'b0;
      bus.ending      = 1'b1;
      frame("resume", 132, 310, 0, 0, 0, 1, 0);

      // Reset during HIT.
      set_pos(1'b0, 80, 300, 130, 300);
      bus.summon_ball = 1'b1;
      frame("rlaunch", 120, 310, 0, 1, 0, 0, 0);
      bus.summon_ball = 1'b0;
      frame("rhit", 120, 310, 0, 1, 1, 0, 20);
      frame("rexpl", 120, 310, 0, 1, 1, 0, 0);
      Reset           = 1'b1;
      bus.summon_ball = 1'b1;
      frame("rreset", 0, 0, 0, 0, 0, 1, 0);
      Reset           = 1'b0;
      bus.summon_ball = 1'b0;
      frame("rrel", 0, 0, 0, 0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/projectile_ball.md
# projectile_ball

Projectile engine that answers a fighter's `summon_ball` request. It launches a ball from the owner's position and moves it once per frame. It detects overlap with the opposing fighter and returns a one-frame `damage` pulse, which feeds that opponent's `damage` input. It then runs an explosion and cooldown sequence before re-asserting `ball_ready` to the owner. One instance per player sits between the two fighter blocks and the sprite renderer.

## Interface
Parameters:
- `SPEED`, 6: pixels moved per frame while flying
- `DAMAGE`, 20: HP value emitted on a hit
- `LAUNCH_DX`, 40: horizontal launch offset from `owner_x`
- `LAUNCH_DY`, 10: vertical launch offset added to `owner_y`
- `HIT_W`, 32: hit window half-width; hit when |ball_x - target_x| < HIT_W
- `HIT_H`, 48: hit window half-height; hit when |ball_y - target_y| < HIT_H
- `EXPLODE_FRAMES`, 8: frames spent in HIT
- `COOLDOWN_FRAMES`, 60: frames spent in COOLDOWN
- `X_MIN`, 0 / `X_MAX`, 600: playfield horizontal limits

Ports:
- `frame_clk`  in  1  frame clock; all state advances on its rising edge
- `Reset`  in  1  synchronous, active-high reset
- `ending`  in  1  match-live flag; 1 = play, 0 = match over
- `summon_ball`  in  1  one-frame launch request from owner
- `owner_face`  in  1  0 = facing right (+x), 1 = facing left (-x)
- `owner_x`, `owner_y`  in  10  owner position, unsigned
- `target_x`, `target_y`  in  10  opponent position, unsigned
- `ball_ready`  out  1  launch permitted
- `ball_active`  out  1  ball sprite visible (FLYING or HIT)
- `ball_exploding`  out  1  state is HIT
- `ball_face`  out  1  latched travel direction
- `ball_x`, `ball_y`  out  10  ball position
- `damage`  out  10  DAMAGE for exactly one frame per hit, else 0

## Operation
- States: READY, FLYING, HIT, COOLDOWN. Reset value: READY, with `ball_x`/`ball_y` = 0, `ball_face` = 0, `damage` = 0, counter = 0.
- `ball_ready` = (state == READY) && `ending`. It is combinational from registered state.
- `ball_active` = state ∈ {FLYING, HIT}.
- `damage` is registered. It defaults to 0 every frame.
- READY:
  - A `summon_ball` sample of 1 with `ending` = 1 moves the state to FLYING.
  - On that transition, latch `ball_face` = `owner_face` and set `ball_y` = `owner_y` + LAUNCH_DY.
  - Set `ball_x` = `owner_x` + LAUNCH_DX for face 0, or `owner_x` - LAUNCH_DX for face 1.
  - Clamp `ball_x` to [X_MIN, X_MAX]. Compute the subtraction as a compare so it never wraps below X_MIN.
- FLYING: evaluate in priority order, on the current registered position.
  1. Overlap: both |dx| < HIT_W and |dy| < HIT_H. Compute each absolute difference with a compare-select so there is no 10-bit wrap. Result: `damage` ← DAMAGE, state ← HIT, counter ← 0. Position holds.
  2. Edge: face 0 with `ball_x` + SPEED > X_MAX, or face 1 with `ball_x` < X_MIN + SPEED. Result: state ← COOLDOWN, counter ← 0.
  3. Otherwise `ball_x` ± SPEED per `ball_face`. `ball_y` is constant.
- HIT: the counter increments each frame. When the counter reaches EXPLODE_FRAMES-1, go to COOLDOWN with counter ← 0.
- COOLDOWN: the counter increments. When it reaches COOLDOWN_FRAMES-1, go to READY.
- `summon_ball` is ignored outside READY. It is not queued.
- When `ending` = 0, from any state the next state is READY and `damage` = 0. `ball_ready` stays low while `ending` = 0.
- A hit always produces exactly one nonzero `damage` frame. It does not repeat while the target stays overlapped.

## Timing
- Launch latency: `summon_ball` sampled high at edge N gives `ball_active` = 1 and the launch position visible after edge N. `ball_ready` falls in the same cycle.
- Hit latency: the overlap position is registered at edge M. `damage` = DAMAGE is visible for the one cycle after edge M+1, and `ball_exploding` = 1 from that same cycle.
- HIT lasts exactly EXPLODE_FRAMES cycles. COOLDOWN lasts exactly COOLDOWN_FRAMES cycles.
- Reset mid-operation returns all outputs to their reset values at the next edge.
- If Reset and `summon_ball` are both high, Reset wins.

## Test plan
- Hit, right-facing:
  - Stimulus: owner (80,300), face 0, target (400,300), `summon_ball` pulse sampled at edge 0.
  - Response: edge 1 ball = (120,310). `ball_x` = 372 at edge 43. `damage` = 20 for exactly one cycle after edge 44. `ball_exploding` is high for 8 cycles. `ball_ready` returns after edge 112.
- Miss, left edge:
  - Stimulus: owner (80,300), face 1, no target overlap, `summon_ball` pulse sampled at edge 0.
  - Response: `ball_x` = 40, 34, 28, 22, 16, 10, 4 at edges 1..7. COOLDOWN at edge 8. `damage` never nonzero. `ball_ready` returns after edge 68.
- Launch clamp:
  - Stimulus: owner_x = 20, face 1, `summon_ball` pulse.
  - Response: launch `ball_x` = 0, with no wrap to ~1004. COOLDOWN on the next edge.
- Summon ignored:
  - Stimulus: `summon_ball` pulses during FLYING, HIT and COOLDOWN.
  - Response: trajectory and counters are unchanged, and there is no relaunch.
- Match end:
  - Stimulus: drop `ending` mid-flight.
  - Response: next edge gives READY, `ball_active` = 0, `damage` = 0, and `ball_ready` = 0 until `ending` returns.
- Reset mid-HIT:
  - Stimulus: assert Reset during HIT.
  - Response: every output takes its reset value after the next edge. After Reset is released with `ending` = 1, `ball_ready` = 1.
